// File: rtl/edge_sync_pkg.sv
// rtl/edge_sync_pkg.sv - shared types and helpers for the multi-channel edge synchronizer
package edge_sync_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // Filter counter only has to reach FILT-1; keep at least one bit so FILT=1 still elaborates.
  function automatic int fcnt_width(input int filt);
    return (filt < 2) ? 1 : $clog2(filt);
  endfunction

endpackage

// File: rtl/edge_sync_chan.sv
// rtl/edge_sync_chan.sv - one channel: sync chain, glitch filter, edge pulse, pending counter
module edge_sync_chan
  import edge_sync_pkg::*;
#(
  parameter int LEN   = 3,
  parameter int FILT  = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             async_i,
  input  edge_mode_e       mode_i,
  input  logic             ack_i,
  input  logic             clr_ovf_i,
  output logic             level_o,
  output logic             pulse_o,
  output logic             pend_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  localparam int             FCW       = fcnt_width(FILT);
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(FILT - 1);

  logic [LEN-1:0]   r_sync;
  logic [FCW-1:0]   r_fcnt;
  logic             r_level;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic             w_diff;
  logic             w_toggle;
  logic             w_sel;
  logic             w_inc;
  logic             w_dec;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ovf_nxt;

  assign w_diff   = r_sync[LEN-1] != r_level;
  assign w_toggle = w_diff && (r_fcnt == FCNT_LAST);

  // The edge about to happen is a rise when the current filtered level is low.
  always_comb begin
    w_sel = 1'b0;
    unique case (mode_i)
      EDGE_OFF:  w_sel = 1'b0;
      EDGE_RISE: w_sel = ~r_level;
      EDGE_FALL: w_sel = r_level;
      EDGE_BOTH: w_sel = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_fcnt  <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[LEN-2:0], async_i};
      r_pulse <= w_toggle && w_sel;
      if (!w_diff) begin
        r_fcnt <= '0;
      end else if (w_toggle) begin
        r_level <= ~r_level;
        r_fcnt  <= '0;
      end else begin
        r_fcnt <= r_fcnt + FCW'(1);
      end
    end
  end

  // The registered pulse feeds the counter, so an ack seen while pulse_o is high cancels it.
  assign w_inc = r_pulse;
  assign w_dec = ack_i && (r_cnt != '0);

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    if (clr_ovf_i) w_ovf_nxt = 1'b0;
    if (w_inc && !w_dec) begin
      if (&r_cnt) w_ovf_nxt = 1'b1;
      else        w_cnt_nxt = r_cnt + CNT_W'(1);
    end else if (w_dec && !w_inc) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign level_o = r_level;
  assign pulse_o = r_pulse;
  assign cnt_o   = r_cnt;
  assign pend_o  = r_cnt != '0;
  assign ovf_o   = r_ovf;

endmodule

// File: rtl/edge_sync_multi.sv
// rtl/edge_sync_multi.sv - CH independent edge synchronizer channels on packed buses
module edge_sync_multi
  import edge_sync_pkg::*;
#(
  parameter int CH    = 4,
  parameter int LEN   = 3,
  parameter int FILT  = 4,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH-1:0]       async_i,
  input  logic [2*CH-1:0]     mode_i,
  input  logic [CH-1:0]       ack_i,
  input  logic                clr_ovf_i,
  output logic [CH-1:0]       level_o,
  output logic [CH-1:0]       pulse_o,
  output logic [CH-1:0]       pend_o,
  output logic [CH*CNT_W-1:0] cnt_o,
  output logic [CH-1:0]       ovf_o
);

  if (LEN < 2) begin : g_bad_len
    $error("edge_sync_multi: LEN must be at least 2");
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    edge_sync_chan #(
      .LEN   (LEN),
      .FILT  (FILT),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .async_i   (async_i[k]),
      .mode_i    (edge_mode_e'(mode_i[2*k +: 2])),
      .ack_i     (ack_i[k]),
      .clr_ovf_i (clr_ovf_i),
      .level_o   (level_o[k]),
      .pulse_o   (pulse_o[k]),
      .pend_o    (pend_o[k]),
      .cnt_o     (cnt_o[k*CNT_W +: CNT_W]),
      .ovf_o     (ovf_o[k])
    );
  end

endmodule

// File: tb/tb_edge_sync_multi.sv
// tb/tb_edge_sync_multi.sv - self-checking bench for edge_sync_multi
module tb_edge_sync_multi;

  localparam int CH    = 4;
  localparam int LEN   = 3;
  localparam int FILT  = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [CH-1:0]       async_i = '0;
  logic [2*CH-1:0]     mode_i = '0;
  logic [CH-1:0]       ack_i = '0;
  logic                clr_ovf_i = 1'b0;
  logic [CH-1:0]       level_o;
  logic [CH-1:0]       pulse_o;
  logic [CH-1:0]       pend_o;
  logic [CH*CNT_W-1:0] cnt_o;
  logic [CH-1:0]       ovf_o;

  int checks = 0;
  int errors = 0;

  edge_sync_multi #(.CH(CH), .LEN(LEN), .FILT(FILT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_i   (async_i),
    .mode_i    (mode_i),
    .ack_i     (ack_i),
    .clr_ovf_i (clr_ovf_i),
    .level_o   (level_o),
    .pulse_o   (pulse_o),
    .pend_o    (pend_o),
    .cnt_o     (cnt_o),
    .ovf_o     (ovf_o)
  );

  always #5 clk = ~clk;

  // Reference model: an input sample reaches the filter LEN edges later, and the level
  // flips once the last FILT filter samples all disagree with it.
  logic [CH-1:0] hist[$];
  int            m_cnt[CH];
  bit            m_level[CH];
  bit            m_pulse[CH];
  bit            m_ovf[CH];

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < LEN + FILT; i++) hist.push_back('0);
    for (int k = 0; k < CH; k++) begin
      m_cnt[k] = 0; m_level[k] = 0; m_pulse[k] = 0; m_ovf[k] = 0;
    end
  endfunction

  function automatic void model_step();
    int last;
    hist.push_back(async_i);
    if (hist.size() > LEN + FILT + 1) void'(hist.pop_front());
    last = hist.size() - 1;
    for (int k = 0; k < CH; k++) begin
      bit inc, dec, set_ovf, all_diff, sel;
      logic [1:0] m;
      inc = m_pulse[k];
      dec = ack_i[k] && (m_cnt[k] > 0);
      set_ovf = 0;
      if (inc && !dec) begin
        if (m_cnt[k] == CMAX) set_ovf = 1;
        else m_cnt[k] = m_cnt[k] + 1;
      end else if (dec && !inc) begin
        m_cnt[k] = m_cnt[k] - 1;
      end
      if (set_ovf) m_ovf[k] = 1;
      else if (clr_ovf_i) m_ovf[k] = 0;
      all_diff = 1;
      for (int j = 0; j < FILT; j++)
        if (hist[last - LEN - j][k] == m_level[k]) all_diff = 0;
      m = mode_i[2*k +: 2];
      sel = (m == 2'b11) || (m == 2'b01 && !m_level[k]) || (m == 2'b10 && m_level[k]);
      m_pulse[k] = all_diff && sel;
      if (all_diff) m_level[k] = !m_level[k];
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    logic [CH-1:0]       e_lvl, e_pul, e_pend, e_ovf;
    logic [CH*CNT_W-1:0] e_cnt;
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < CH; k++) begin
      e_lvl[k]  = m_level[k];
      e_pul[k]  = m_pulse[k];
      e_ovf[k]  = m_ovf[k];
      e_pend[k] = m_cnt[k] != 0;
      e_cnt[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
    end
    chk("model_level", 64'(level_o), 64'(e_lvl));
    chk("model_pulse", 64'(pulse_o), 64'(e_pul));
    chk("model_pend",  64'(pend_o),  64'(e_pend));
    chk("model_cnt",   64'(cnt_o),   64'(e_cnt));
    chk("model_ovf",   64'(ovf_o),   64'(e_ovf));
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_all_zero", 64'({level_o, pulse_o, pend_o, cnt_o, ovf_o}), 64'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    int                  cyc;
    logic [CH-1:0]       async_v;
    logic [CH-1:0]       exp_level;
    logic [CH-1:0]       exp_pulse;
    logic [CH*CNT_W-1:0] exp_cnt;
  } vec_t;

  vec_t vt[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    vt[0] = '{3,  4'b0011, 4'b0000, 4'b0000, 16'h0000};
    vt[1] = '{3,  4'b0001, 4'b0000, 4'b0000, 16'h0000};
    vt[2] = '{1,  4'b0001, 4'b0001, 4'b0001, 16'h0000};
    vt[3] = '{1,  4'b0001, 4'b0001, 4'b0000, 16'h0001};
    vt[4] = '{10, 4'b0001, 4'b0001, 4'b0000, 16'h0001};

    model_reset();
    mode_i = 8'b10_11_01_01;
    #20;
    chk("reset_all_zero", 64'({level_o, pulse_o, pend_o, cnt_o, ovf_o}), 64'd0);
    #2;
    rst_n = 1'b1;

    // ch0 rise with latency LEN+FILT, ch1 three-cycle glitch rejected
    for (int i = 0; i < 5; i++) begin
      async_i = vt[i].async_v;
      repeat (vt[i].cyc) tick();
      chk("tbl_level", 64'(level_o), 64'(vt[i].exp_level));
      chk("tbl_pulse", 64'(pulse_o), 64'(vt[i].exp_pulse));
      chk("tbl_cnt",   64'(cnt_o),   64'(vt[i].exp_cnt));
    end

    // ch2 both edges, then drain with acks and one extra ack at zero
    async_i[2] = 1'b1;
    repeat (7) tick();
    chk("ch2_rise_pulse", 64'({level_o[2], pulse_o[2]}), 64'b11);
    repeat (13) tick();
    async_i[2] = 1'b0;
    repeat (7) tick();
    chk("ch2_fall_pulse", 64'({level_o[2], pulse_o[2]}), 64'b01);
    tick();
    chk("ch2_cnt2", 64'(cnt_o[11:8]), 64'd2);
    for (int i = 0; i < 3; i++) begin
      ack_i[2] = 1'b1;
      tick();
      ack_i[2] = 1'b0;
      chk("ch2_ack_cnt", 64'(cnt_o[11:8]), (i == 0) ? 64'd1 : 64'd0);
    end
    chk("ch2_pend_clear", 64'(pend_o[2]), 64'd0);

    // ch3 falling-edge saturation and overflow
    for (int i = 0; i < 16; i++) begin
      async_i[3] = 1'b1;
      repeat (8) tick();
      async_i[3] = 1'b0;
      repeat (8) tick();
      if (i == 14) chk("ch3_no_ovf_at_15", 64'({cnt_o[15:12], ovf_o[3]}), 64'({4'd15, 1'b0}));
    end
    chk("ch3_saturated", 64'({cnt_o[15:12], ovf_o[3]}), 64'({4'd15, 1'b1}));
    clr_ovf_i = 1'b1;
    tick();
    clr_ovf_i = 1'b0;
    chk("ch3_ovf_cleared", 64'({cnt_o[15:12], ovf_o[3]}), 64'({4'd15, 1'b0}));
    async_i[3] = 1'b1;
    repeat (8) tick();
    async_i[3] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (pulse_o[3]) found = 1'b1;
    end
    chk("ch3_pulse_seen", 64'(found), 64'd1);
    clr_ovf_i = 1'b1;
    tick();
    clr_ovf_i = 1'b0;
    chk("ch3_set_beats_clear", 64'(ovf_o[3]), 64'd1);

    // ch0 up to five pending, then an ack coincident with pulse_o
    for (int i = 0; i < 4; i++) begin
      async_i[0] = 1'b0;
      repeat (8) tick();
      async_i[0] = 1'b1;
      repeat (8) tick();
    end
    chk("ch0_cnt5", 64'(cnt_o[3:0]), 64'd5);
    async_i[0] = 1'b0;
    repeat (8) tick();
    async_i[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (pulse_o[0]) found = 1'b1;
    end
    chk("ch0_pulse_seen", 64'(found), 64'd1);
    ack_i[0] = 1'b1;
    tick();
    ack_i[0] = 1'b0;
    chk("ch0_inc_dec_hold", 64'(cnt_o[3:0]), 64'd5);

    // mode 00: level follows, no pulse, count untouched
    mode_i[1:0] = 2'b00;
    async_i[0]  = 1'b0;
    found = 1'b0;
    repeat (10) begin
      tick();
      if (pulse_o[0]) found = 1'b1;
    end
    chk("ch0_off_level", 64'(level_o[0]), 64'd0);
    chk("ch0_off_nopulse", 64'(found), 64'd0);
    chk("ch0_off_cnt", 64'(cnt_o[3:0]), 64'd5);

    // reset mid-filter with three pending, input held high through release
    ack_i[0] = 1'b1;
    repeat (2) tick();
    ack_i[0] = 1'b0;
    chk("ch0_cnt3", 64'(cnt_o[3:0]), 64'd3);
    mode_i[1:0] = 2'b01;
    async_i[0]  = 1'b1;
    repeat (5) tick();
    mid_reset();
    repeat (6) tick();
    chk("post_reset_wait", 64'({level_o[0], pulse_o[0]}), 64'b00);
    tick();
    chk("post_reset_rise", 64'({level_o[0], pulse_o[0]}), 64'b11);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < CH; k++) begin
        if ($urandom_range(5) == 0) async_i[k] = ~async_i[k];
        if ($urandom_range(49) == 0) mode_i[2*k +: 2] = 2'($urandom_range(3));
        ack_i[k] = ($urandom_range(3) == 0);
      end
      clr_ovf_i = ($urandom_range(39) == 0);
      if (c == 1500) mid_reset();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_sync_multi.md
Name: edge_sync_multi

Overview:
- Multi-channel successor to the single-edge synchronizer.
- Brings CH asynchronous level signals into the clk domain through an LEN-stage sync chain and a per-channel glitch filter.
- Detects runtime-selectable edges per channel, emitting a one-cycle pulse and a filtered level per channel.
- Queues detected events in a per-channel saturating pending counter that downstream logic consumes with ack_i. Used for video-timing and control-strobe crossings into the AXI clock domain.

Parameters:
CH, 4, number of independent channels (>=1)
LEN, 3, synchronizer stages per channel (>=2; elaboration error otherwise)
FILT, 4, stable cycles required before a level change is accepted (>=1; 1 = no filtering)
CNT_W, 4, width of each pending-event counter (>=1)

Ports:
clk  in  1  single clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
async_i  in  CH  asynchronous level inputs, one per channel
mode_i  in  2*CH  per-channel edge select, channel k at [2k+1:2k]
ack_i  in  CH  per-channel consume strobe, synchronous
clr_ovf_i  in  1  clears all overflow flags, synchronous
level_o  out  CH  synchronized, filtered level
pulse_o  out  CH  one-cycle pulse on selected edge
pend_o  out  CH  pending count nonzero
cnt_o  out  CH*CNT_W  pending counts, channel k at [k*CNT_W +: CNT_W]
ovf_o  out  CH  sticky overflow

Behaviour:
- Reset values (rst_n low, asynchronous): sync chains 0, filter counters 0, level_o 0, pulse_o 0, cnt_o 0, pend_o 0, ovf_o 0.
- An input high at reset release produces a rising event after the normal latency.
- Sync chain: s[0] <= async_i, s[i] <= s[i-1]; the sync output is s[LEN-1].
- Filter, per channel, each edge:
  - If s[LEN-1] == level_o: fcnt <= 0.
  - Else if fcnt == FILT-1: level_o toggles, fcnt <= 0.
  - Else: fcnt++.
- Glitches shorter than FILT cycles at s[LEN-1] never reach level_o.
- Latency: an input change meeting setup before edge 1 changes level_o at edge LEN+FILT. With the defaults that is edge 7.
- Mode encoding (registered, no extra latency):
  - 00: disabled; level_o still tracks, no pulse.
  - 01: rise.
  - 10: fall.
  - 11: both.
- pulse_o is registered and asserts for exactly one cycle, coincident with the level_o toggle, when that edge is selected by mode_i as sampled at the toggle edge.
- Counter, per channel:
  - inc = selected-edge pulse; dec = ack_i && cnt != 0.
  - inc & dec: cnt unchanged.
  - inc only, cnt < max: cnt++.
  - inc only, cnt == 2^CNT_W-1: cnt holds and ovf_o sets.
  - dec only: cnt--.
  - ack_i at cnt == 0: ignored, no underflow.
- pend_o = (cnt != 0), combinational from the counter register.
- ovf_o is sticky. clr_ovf_i clears all channels; a simultaneous overflow set on a channel wins over clear.
- Channels are fully independent; there is no cross-channel ordering.
- Mode change mid-filter does not reset fcnt.
- Reset mid-operation discards all pending events and filter progress.

Decomposition:
- Package edge_sync_pkg:
  - typedef enum logic [1:0] edge_mode_e {EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH}.
  - Helper function for filter-counter width: $clog2(FILT) with minimum 1.
- Sub-module edge_sync_chan holds one channel (sync chain, filter, edge detect, counter, ovf). The top instantiates it CH times via generate, slicing the packed buses.

Test Plan:
- Defaults, ch0 mode=01, async_i[0] 0->1 before edge 1 -> level_o[0]=1 and pulse_o[0]=1 for one cycle at edge 7; cnt ch0=1, pend_o[0]=1.
- ch1 mode=01, 3-cycle high glitch on async_i[1] -> level_o[1], pulse_o[1], cnt ch1 all stay 0.
- ch2 mode=11, input 0->1 then 1->0 twenty cycles later -> two pulses, cnt ch2=2; two ack_i[2] strobes -> cnt ch2=0, pend_o[2]=0. A third ack at 0 leaves cnt at 0.
- ch3 mode=10, 16 falling edges with no ack -> cnt ch3 saturates at 15, ovf_o[3]=1 on the 16th. clr_ovf_i -> ovf_o[3]=0. Overflow coinciding with clr_ovf_i -> ovf_o[3] stays 1.
- ack_i[0] on the same cycle as pulse_o[0] with cnt ch0=5 -> cnt ch0 stays 5. mode=00 with an input edge -> level_o toggles, no pulse, cnt unchanged.
- rst_n low mid-filter with cnt ch0=3 -> all outputs 0 immediately. async_i[0] held high through release -> rise pulse at edge 7 after release.
